// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_operand_loader
// Brief    : Collects eight operand words from a valid/ready stream into
//            2x2 matrices A and B and presents them with a valid/ack handshake.
//            Define LOADER_TRANSPOSE_B_EN to store matrix B transposed.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_operand_loader #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [WORD_W-1:0] arr1_0,
    output logic [WORD_W-1:0] arr1_1,
    output logic [WORD_W-1:0] arr1_2,
    output logic [WORD_W-1:0] arr1_3,
    output logic [WORD_W-1:0] arr2_0,
    output logic [WORD_W-1:0] arr2_1,
    output logic [WORD_W-1:0] arr2_2,
    output logic [WORD_W-1:0] arr2_3,
    output logic              mats_valid,
    input  logic              mats_ack,
    output logic [3:0]        load_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_A_LAST = 4'd3;
    localparam logic [3:0] c_CNT_B_LAST = 4'd7;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_load_cnt;
    logic [3:0]        w_load_cnt_nxt;
    logic              r_mats_valid;
    logic [WORD_W-1:0] r_arr1 [4];
    logic [WORD_W-1:0] r_arr2 [4];
    logic              w_loading;
    logic              w_clear;
    logic              w_xfer;
    logic [1:0]        w_b_idx;

    assign w_loading = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_clear   = clear && (r_state != S_IDLE);
    // A clear in the same cycle drops the offered word
    assign w_xfer    = in_valid && w_loading && !w_clear;

`ifdef LOADER_TRANSPOSE_B_EN
    // Swapping the index bits turns column-major arrival into row-major storage
    assign w_b_idx = {r_load_cnt[0], r_load_cnt[1]};
`else
    assign w_b_idx = r_load_cnt[1:0];
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_load_cnt_nxt = r_load_cnt;
        case (r_state)
            S_IDLE: begin
                w_state_nxt    = S_LOAD_A;
                w_load_cnt_nxt = 4'd0;
            end
            S_LOAD_A: begin
                if (w_xfer) begin
                    w_load_cnt_nxt = r_load_cnt + 4'd1;
                    if (r_load_cnt == c_CNT_A_LAST) begin
                        w_state_nxt = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (w_xfer) begin
                    w_load_cnt_nxt = r_load_cnt + 4'd1;
                    if (r_load_cnt == c_CNT_B_LAST) begin
                        w_state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (mats_ack) begin
                    w_state_nxt    = S_LOAD_A;
                    w_load_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_load_cnt_nxt = 4'd0;
            end
        endcase
        if (w_clear) begin
            w_state_nxt    = S_LOAD_A;
            w_load_cnt_nxt = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_load_cnt   <= 4'd0;
            r_mats_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_arr1[i] <= '0;
                r_arr2[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_load_cnt   <= w_load_cnt_nxt;
            r_mats_valid <= (w_state_nxt == S_FULL);
            if (w_xfer) begin
                if (!r_load_cnt[2]) begin
                    r_arr1[r_load_cnt[1:0]] <= in_data;
                end else begin
                    r_arr2[w_b_idx] <= in_data;
                end
            end
        end
    end

    assign in_ready   = w_loading;
    assign mats_valid = r_mats_valid;
    assign load_cnt   = r_load_cnt;
    assign arr1_0     = r_arr1[0];
    assign arr1_1     = r_arr1[1];
    assign arr1_2     = r_arr1[2];
    assign arr1_3     = r_arr1[3];
    assign arr2_0     = r_arr2[0];
    assign arr2_1     = r_arr2[1];
    assign arr2_2     = r_arr2[2];
    assign arr2_3     = r_arr2[3];

endmodule
`default_nettype wire
